// File: rtl/ac97_codec_link.sv
// Codec-side AC'97 link: bit clock generation, command/playback receive, status/capture transmit.
// Optional AC97_LOOPBACK_EN: register 0x1E bit0 routes received playback samples into capture slots.
`timescale 1ns/1ps
module ac97_codec_link #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned READY_DLY = 64,
  parameter logic [15:0] RESET_ID  = 16'h0D40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AC97_RST,
  output logic        AC_97_BIT_CLK,
  input  logic        AC97_SYNC,
  input  logic        AC97_SDATA_OUT,
  output logic        AC97_SDATA_IN,
  input  logic [15:0] adc_left,
  input  logic [15:0] adc_right,
  input  logic        adc_valid,
  output logic [15:0] dac_left,
  output logic [15:0] dac_right,
  output logic        dac_valid,
  output logic        codec_ready
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RDY_W = $clog2(READY_DLY + 1);

  logic             srst_c;
  logic [DIV_W-1:0] div_cnt;
  logic             div_tc_c;
  logic             rise_c;
  logic             fall_c;
  logic             sync_q;
  logic             frame_start_c;
  logic [RDY_W-1:0] rdy_cnt;

  logic        rx_act;
  logic [7:0]  rx_cnt;
  logic [18:0] rx_sh;
  logic [19:0] rx_word_c;
  logic [4:0]  rx_tag;
  logic        rx_rd;
  logic [6:0]  rx_addr;
  logic [15:0] rx_left;
  logic        rd_pend;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data_c;
  logic [15:0] regs [16];
`ifdef AC97_LOOPBACK_EN
  logic        dac_seen;
`endif

  logic        tx_act;
  logic [7:0]  tx_cnt;
  logic [15:0] tx_tag;
  logic [19:0] tx_s1;
  logic [19:0] tx_s2;
  logic [19:0] tx_s3;
  logic [19:0] tx_s4;
  logic        tx_bit_c;
  logic [15:0] cap_l_c;
  logic [15:0] cap_r_c;
  logic        cap_v_c;

  assign srst_c        = !rst || !AC97_RST;
  assign div_tc_c      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_c        = div_tc_c && !AC_97_BIT_CLK;
  assign fall_c        = div_tc_c && AC_97_BIT_CLK;
  assign frame_start_c = fall_c && AC97_SYNC && !sync_q;
  assign rx_word_c     = {rx_sh, AC97_SDATA_OUT};

  // Bit clock divider
  always_ff @(posedge clk) begin
    if (srst_c) begin
      div_cnt       <= '0;
      AC_97_BIT_CLK <= 1'b0;
    end else if (div_tc_c) begin
      div_cnt       <= '0;
      AC_97_BIT_CLK <= ~AC_97_BIT_CLK;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Codec-ready delay counted in bit clock rise strobes
  always_ff @(posedge clk) begin
    if (srst_c) begin
      rdy_cnt     <= '0;
      codec_ready <= 1'b0;
    end else if (rise_c && !codec_ready) begin
      if (rdy_cnt == RDY_W'(READY_DLY - 1)) codec_ready <= 1'b1;
      else                                   rdy_cnt     <= rdy_cnt + RDY_W'(1);
    end
  end

  always_comb begin
    rd_data_c = 16'h0000;
    if (rd_addr == 7'h00)      rd_data_c = RESET_ID;
    else if (rd_addr <= 7'h1E) rd_data_c = regs[rd_addr[4:1]];
  end

  // Receive: slots decoded as their last bit is sampled, so a restarted frame discards partial slots
  always_ff @(posedge clk) begin
    if (srst_c) begin
      sync_q    <= 1'b0;
      rx_act    <= 1'b0;
      rx_cnt    <= 8'd0;
      rx_sh     <= '0;
      rx_tag    <= '0;
      rx_rd     <= 1'b0;
      rx_addr   <= '0;
      rx_left   <= '0;
      rd_pend   <= 1'b0;
      rd_addr   <= '0;
      dac_left  <= '0;
      dac_right <= '0;
      dac_valid <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
`ifdef AC97_LOOPBACK_EN
      dac_seen  <= 1'b0;
`endif
    end else begin
      dac_valid <= 1'b0;
      if (fall_c) sync_q <= AC97_SYNC;
      if (frame_start_c) begin
        rx_act  <= 1'b1;
        rx_cnt  <= 8'd0;
        rd_pend <= 1'b0;
      end else if (fall_c && rx_act) begin
        rx_sh <= rx_word_c[18:0];
        if (rx_cnt == 8'd255) rx_act <= 1'b0;
        else                  rx_cnt <= rx_cnt + 8'd1;
        case (rx_cnt)
          8'd15: rx_tag <= rx_word_c[15:11];
          8'd35: begin
            rx_rd   <= rx_word_c[19];
            rx_addr <= rx_word_c[18:12];
            if (rx_tag[4] && rx_tag[3] && rx_word_c[19]) begin
              rd_pend <= 1'b1;
              rd_addr <= rx_word_c[18:12];
            end
          end
          8'd55: begin
            if (rx_tag[4] && rx_tag[3] && rx_tag[2] && !rx_rd && rx_addr <= 7'h1E) begin
              if (rx_addr[4:1] == 4'd0) begin
                for (int i = 0; i < 16; i++) regs[i] <= '0;
              end else begin
                regs[rx_addr[4:1]] <= rx_word_c[19:4];
              end
            end
          end
          8'd75: rx_left <= rx_word_c[19:4];
          8'd95: begin
            if (rx_tag[1] && rx_tag[0]) begin
              dac_left  <= rx_left;
              dac_right <= rx_word_c[19:4];
              dac_valid <= 1'b1;
`ifdef AC97_LOOPBACK_EN
              dac_seen  <= 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Capture source selection
  always_comb begin
    cap_l_c = adc_left;
    cap_r_c = adc_right;
    cap_v_c = adc_valid;
`ifdef AC97_LOOPBACK_EN
    if (regs[15][0]) begin
      cap_l_c = dac_left;
      cap_r_c = dac_right;
      cap_v_c = dac_seen;
    end
`endif
  end

  // Serialiser: bit index within the outgoing frame
  always_comb begin
    tx_bit_c = 1'b0;
    if (tx_cnt < 8'd16)      tx_bit_c = tx_tag[4'(8'd15 - tx_cnt)];
    else if (tx_cnt < 8'd36) tx_bit_c = tx_s1[5'(8'd35 - tx_cnt)];
    else if (tx_cnt < 8'd56) tx_bit_c = tx_s2[5'(8'd55 - tx_cnt)];
    else if (tx_cnt < 8'd76) tx_bit_c = tx_s3[5'(8'd75 - tx_cnt)];
    else if (tx_cnt < 8'd96) tx_bit_c = tx_s4[5'(8'd95 - tx_cnt)];
  end

  // Transmit: frame contents snapshotted at frame start, shifted out on rise strobes
  always_ff @(posedge clk) begin
    if (srst_c) begin
      tx_act        <= 1'b0;
      tx_cnt        <= 8'd0;
      tx_tag        <= '0;
      tx_s1         <= '0;
      tx_s2         <= '0;
      tx_s3         <= '0;
      tx_s4         <= '0;
      AC97_SDATA_IN <= 1'b0;
    end else if (frame_start_c) begin
      tx_act <= 1'b1;
      tx_cnt <= 8'd0;
      tx_tag <= {codec_ready, rd_pend, rd_pend, cap_v_c, cap_v_c, 11'd0};
      tx_s1  <= rd_pend ? {1'b0, rd_addr, 12'h000} : 20'h00000;
      tx_s2  <= rd_pend ? {rd_data_c, 4'h0} : 20'h00000;
      tx_s3  <= cap_v_c ? {cap_l_c, 4'h0} : 20'h00000;
      tx_s4  <= cap_v_c ? {cap_r_c, 4'h0} : 20'h00000;
    end else if (rise_c) begin
      if (tx_act) begin
        AC97_SDATA_IN <= tx_bit_c;
        if (tx_cnt == 8'd255) tx_act <= 1'b0;
        else                  tx_cnt <= tx_cnt + 8'd1;
      end else begin
        AC97_SDATA_IN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ac97_codec_link.sv
// Directed bench for ac97_codec_link: plays the controller side of the link and checks decoded frames.
`timescale 1ns/1ps
module tb_ac97_codec_link;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ac97_rst = 1'b1;
  logic        sync = 1'b0;
  logic        sdo = 1'b0;
  logic        bit_clk;
  logic        sdi;
  logic [15:0] adc_l = 16'h0;
  logic [15:0] adc_r = 16'h0;
  logic        adc_v = 1'b0;
  logic [15:0] dac_l;
  logic [15:0] dac_r;
  logic        dac_v;
  logic        rdy;

  int n_chk  = 0;
  int n_pass = 0;
  int dv_cnt = 0;

  ac97_codec_link dut (
    .clk(clk), .rst(rst), .AC97_RST(ac97_rst), .AC_97_BIT_CLK(bit_clk),
    .AC97_SYNC(sync), .AC97_SDATA_OUT(sdo), .AC97_SDATA_IN(sdi),
    .adc_left(adc_l), .adc_right(adc_r), .adc_valid(adc_v),
    .dac_left(dac_l), .dac_right(dac_r), .dac_valid(dac_v), .codec_ready(rdy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dac_v === 1'b1) dv_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [255:0] mk(input logic [15:0] tag, input logic [19:0] s1,
                                      input logic [19:0] s2, input logic [19:0] s3,
                                      input logic [19:0] s4);
    return {tag, s1, s2, s3, s4, 160'd0};
  endfunction

  // One controller frame; stop_at >= 0 truncates it so the next call restarts mid-frame
  task automatic xfer(input logic [255:0] fr, input int stop_at, output logic [255:0] rx);
    rx = '0;
    @(posedge bit_clk); #1;
    sync = 1'b1;
    sdo  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == stop_at) break;
      @(posedge bit_clk); #1;
      sdo  = fr[255-i];
      sync = (i < 16);
      @(negedge bit_clk); #1;
      rx[255-i] = sdi;
    end
  endtask

  logic [255:0] r;
  int           k;
  int           d0;
  logic         sdi_bad;
  time          t0;

  initial begin
    // Reset state
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rst_bitclk", bit_clk, 0);
    check("rst_sdi", sdi, 0);
    check("rst_dac_l", dac_l, 0);
    check("rst_dac_v", dac_v, 0);
    check("rst_ready", rdy, 0);

    // Ready delay and bit clock period
    rst = 1'b1;
    k = 0;
    sdi_bad = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge bit_clk); #1;
      if (sdi !== 1'b0) sdi_bad = 1'b1;
      if (rdy === 1'b1) begin
        k = i;
        break;
      end
    end
    check("ready_rise_index", 32'(k), 64);
    check("sdi_idle", sdi_bad, 0);
    @(posedge bit_clk); t0 = $time;
    @(posedge bit_clk);
    check("bitclk_period_ns", 32'($time - t0), 40);

    // Idle frame
    xfer(mk(16'h0000, 0, 0, 0, 0), -1, r);
    check("idle_tag", r[255:240], 16'h8000);
    check("idle_s1", r[239:220], 0);
    check("idle_s3", r[199:180], 0);

    // Register write/read, with an ignored out-of-range write in between
    xfer(mk(16'hE000, 20'h02000, 20'h12340, 0, 0), -1, r);
    xfer(mk(16'hE000, 20'h22000, 20'hBEEF0, 0, 0), -1, r);
    xfer(mk(16'hC000, 20'h82000, 0, 0, 0), -1, r);
    check("rd_frameN_tag", r[255:240], 16'h8000);
    xfer(mk(16'h0000, 0, 0, 0, 0), -1, r);
    check("rd02_tag", r[255:240], 16'hE000);
    check("rd02_s1", r[239:220], 20'h02000);
    check("rd02_s2", r[219:200], 20'h12340);

    // Reset ID and unmapped address
    xfer(mk(16'hC000, 20'h80000, 0, 0, 0), -1, r);
    xfer(mk(16'hC000, 20'hC0000, 0, 0, 0), -1, r);
    check("rd00_s2", r[219:200], 20'h0D400);
    xfer(mk(16'h0000, 0, 0, 0, 0), -1, r);
    check("rd40_s1", r[239:220], 20'h40000);
    check("rd40_s2", r[219:200], 20'h00000);

    // Playback slots
    d0 = dv_cnt;
    xfer(mk(16'h9800, 0, 0, 20'hABCD0, 20'h55AA0), -1, r);
    check("pb_pulses", 32'(dv_cnt - d0), 1);
    check("pb_dac_l", dac_l, 16'hABCD);
    check("pb_dac_r", dac_r, 16'h55AA);
    d0 = dv_cnt;
    xfer(mk(16'h9000, 0, 0, 20'h11110, 20'h22220), -1, r);
    check("pb_novalid_pulses", 32'(dv_cnt - d0), 0);
    check("pb_novalid_dac_l", dac_l, 16'hABCD);
    d0 = dv_cnt;
    xfer(mk(16'h9800, 0, 0, 20'h33330, 20'h44440), 90, r);
    check("pb_abort_pulses", 32'(dv_cnt - d0), 0);
    check("pb_abort_dac_r", dac_r, 16'h55AA);

    // Capture slots
    adc_l = 16'h7FFF;
    adc_r = 16'h8001;
    adc_v = 1'b1;
    xfer(mk(16'h0000, 0, 0, 0, 0), -1, r);
    adc_v = 1'b0;
    check("cap_tag", r[255:240], 16'h9800);
    check("cap_s3", r[199:180], 20'h7FFF0);
    check("cap_s4", r[179:160], 20'h80010);

    // Write aborted at bit 40 must not commit
    xfer(mk(16'hE000, 20'h02000, 20'h55550, 0, 0), 40, r);
    xfer(mk(16'hC000, 20'h82000, 0, 0, 0), -1, r);
    xfer(mk(16'h0000, 0, 0, 0, 0), -1, r);
    check("abort_wr_s2", r[219:200], 20'h12340);

    // Register 0x1E bit0: loopback select when built with the option
    xfer(mk(16'hE000, 20'h1E000, 20'h00010, 0, 0), -1, r);
    xfer(mk(16'hC000, 20'h9E000, 0, 0, 0), -1, r);
    adc_v = 1'b1;
    xfer(mk(16'h0000, 0, 0, 0, 0), -1, r);
    adc_v = 1'b0;
    check("rd1e_s2", r[219:200], 20'h00010);
    check("lb_tag", r[255:240], 16'hF800);
`ifdef AC97_LOOPBACK_EN
    check("lb_s3", r[199:180], 20'hABCD0);
    check("lb_s4", r[179:160], 20'h55AA0);
`else
    check("lb_s3", r[199:180], 20'h7FFF0);
    check("lb_s4", r[179:160], 20'h80010);
`endif

    // Write to 0x00 clears the register file
    xfer(mk(16'hE000, 20'h00000, 20'hFFFF0, 0, 0), -1, r);
    xfer(mk(16'hC000, 20'h82000, 0, 0, 0), -1, r);
    xfer(mk(16'h0000, 0, 0, 0, 0), -1, r);
    check("clr_rd02_s2", r[219:200], 20'h00000);

    // Controller cold reset mid-frame
    @(posedge bit_clk); #1;
    sync = 1'b1;
    @(posedge bit_clk); #1;
    check("pre_rst_sdi", sdi, 1);
    @(negedge clk);
    ac97_rst = 1'b0;
    @(posedge clk); #1;
    check("cold_rst_bitclk", bit_clk, 0);
    check("cold_rst_sdi", sdi, 0);
    check("cold_rst_dac_l", dac_l, 0);
    check("cold_rst_dac_r", dac_r, 0);
    check("cold_rst_ready", rdy, 0);
    check("cold_rst_dac_v", dac_v, 0);
    sync = 1'b0;
    repeat (3) @(negedge clk);
    ac97_rst = 1'b1;
    repeat (8) @(posedge bit_clk);
    xfer(mk(16'hC000, 20'h82000, 0, 0, 0), -1, r);
    xfer(mk(16'h0000, 0, 0, 0, 0), -1, r);
    check("post_rst_rd02_s2", r[219:200], 20'h00000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
